mem_stage_ctrl: RTL and testbench

- Consumer end of the EX/MEM pipeline register: takes the MEM-stage fields and runs the data-memory access.
- Drives a req/ready handshake to the data memory and stalls the upstream pipeline while an access is outstanding.
- Produces the MEM/WB register contents and the branch redirect.
- Sits between the EX/MEM register and the writeback mux.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/dmem_handshake.sv | 114 +++++++++++
 rtl/mem_stage_ctrl.sv | 87 ++++++++
 tb/tb_mem_stage_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM pipeline stage: access FSM states,
// datapath widths and the fill word returned by an aborted access.
package pipe_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [DATA_W-1:0] TIMEOUT_FILL = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;
endpackage

// File: rtl/dmem_handshake.sv
// Data-memory request FSM: latches one access, holds req until ready, buffers the
// load data. Optional DMEM_TIMEOUT_EN adds an abort counter and sticky err.
module dmem_handshake
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memop,
  input  logic              is_store,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] load_buf,
  output logic              err
);

  mem_state_t        state_reg, state_next;
  logic              req_reg, we_reg;
  logic [DATA_W-1:0] addr_reg, wdata_reg, buf_reg;
  logic              timeout;
  logic              done;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  // The abort fires on the cycle the counter would reach TIMEOUT_CYCLES,
  // so req is high for exactly TIMEOUT_CYCLES cycles.
  assign timeout = (state_reg == REQ) && !dmem_ready && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (state_reg == REQ && !dmem_ready && !timeout) cnt_reg <= cnt_reg + 1'b1;
      else                                             cnt_reg <= '0;
      if (timeout) err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign done = (state_reg == REQ) && (dmem_ready || timeout);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (memop) begin
          stall      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (done) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      buf_reg   <= '0;
    end else begin
      if (state_reg == IDLE && memop) begin
        req_reg   <= 1'b1;
        we_reg    <= is_store;
        addr_reg  <= addr;
        wdata_reg <= wdata;
      end else if (done) begin
        req_reg <= 1'b0;
      end
      if (state_reg == REQ) begin
        if (dmem_ready)   buf_reg <= dmem_rdata;
        else if (timeout) buf_reg <= TIMEOUT_FILL;
      end
    end
  end

  assign dmem_req   = req_reg;
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_wdata = wdata_reg;
  assign load_buf   = buf_reg;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: data-memory access control, MEM/WB register and branch
// redirect. DMEM_TIMEOUT_EN enables the access-abort timeout and err flag.
module mem_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     pc_branch_MEM,
  input  logic                  zero_MEM,
  input  logic [DATA_W-1:0]     alu_MEM,
  input  logic [DATA_W-1:0]     writedata_MEM,
  input  logic [REG_ADDR_W-1:0] rd_MEM,
  input  logic                  branch_MEM,
  input  logic                  memread_MEM,
  input  logic                  memtoreg_MEM,
  input  logic                  memwrite_MEM,
  input  logic                  regwrite_MEM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  stall,
  output logic                  pcsrc,
  output logic [DATA_W-1:0]     pc_target,
  output logic [DATA_W-1:0]     readdata_WB,
  output logic [DATA_W-1:0]     alu_WB,
  output logic [REG_ADDR_W-1:0] rd_WB,
  output logic                  memtoreg_WB,
  output logic                  regwrite_WB,
  output logic                  err
);

  logic              memop, is_load;
  logic [DATA_W-1:0] load_buf;

  // A simultaneous read+write request is handled as a store.
  assign memop   = memread_MEM | memwrite_MEM;
  assign is_load = memread_MEM & ~memwrite_MEM;

  assign pcsrc     = branch_MEM & zero_MEM;
  assign pc_target = pc_branch_MEM;

  dmem_handshake #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_hs (
    .clk       (clk),
    .rst       (rst),
    .memop     (memop),
    .is_store  (memwrite_MEM),
    .addr      (alu_MEM),
    .wdata     (writedata_MEM),
    .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .stall     (stall),
    .load_buf  (load_buf),
    .err       (err)
  );

  // Stalled edges insert a bubble: control cleared so WB never writes twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      readdata_WB <= '0;
      alu_WB      <= '0;
      rd_WB       <= '0;
      memtoreg_WB <= 1'b0;
      regwrite_WB <= 1'b0;
    end else if (!stall) begin
      readdata_WB <= is_load ? load_buf : '0;
      alu_WB      <= alu_MEM;
      rd_WB       <= rd_MEM;
      memtoreg_WB <= memtoreg_MEM;
      regwrite_WB <= regwrite_MEM;
    end else begin
      memtoreg_WB <= 1'b0;
      regwrite_WB <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: issue tasks push expected MEM/WB and
// memory-request records; monitors pop and compare as the DUT presents them.
module tb_mem_stage_ctrl;

`ifdef DMEM_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_branch_MEM, alu_MEM, writedata_MEM;
  logic        zero_MEM, branch_MEM, memread_MEM, memtoreg_MEM, memwrite_MEM, regwrite_MEM;
  logic [4:0]  rd_MEM;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, pcsrc, memtoreg_WB, regwrite_WB, err;
  logic [31:0] pc_target, readdata_WB, alu_WB;
  logic [4:0]  rd_WB;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .pc_branch_MEM(pc_branch_MEM), .zero_MEM(zero_MEM), .alu_MEM(alu_MEM),
    .writedata_MEM(writedata_MEM), .rd_MEM(rd_MEM), .branch_MEM(branch_MEM),
    .memread_MEM(memread_MEM), .memtoreg_MEM(memtoreg_MEM),
    .memwrite_MEM(memwrite_MEM), .regwrite_MEM(regwrite_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall(stall), .pcsrc(pcsrc), .pc_target(pc_target),
    .readdata_WB(readdata_WB), .alu_WB(alu_WB), .rd_WB(rd_WB),
    .memtoreg_WB(memtoreg_WB), .regwrite_WB(regwrite_WB), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        mtr;
    logic        rw;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  logic        issue_active = 1'b0;
  int          ready_lat    = 0;
  logic [31:0] resp_data    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: ready on the ready_lat-th request cycle (0 = never).
  int req_cnt = 0;
  always @(negedge clk) begin
    dmem_rdata = resp_data;
    if (dmem_req === 1'b1) begin
      req_cnt++;
      dmem_ready = (ready_lat != 0) && (req_cnt == ready_lat);
    end else begin
      req_cnt    = 0;
      dmem_ready = 1'b0;
    end
  end

  // MEM/WB monitor: every unstalled edge while an instruction is issued retires it.
  logic wb_load = 1'b0;
  always @(posedge clk) wb_load = (rst === 1'b0) && (stall === 1'b0) && issue_active;

  always @(negedge clk) begin
    if (wb_load) begin
      if (wb_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check("alu_WB", alu_WB, e.alu);
        check("readdata_WB", readdata_WB, e.rdata);
        check("rd_WB", {27'd0, rd_WB}, {27'd0, e.rd});
        check("memtoreg_WB", {31'd0, memtoreg_WB}, {31'd0, e.mtr});
        check("regwrite_WB", {31'd0, regwrite_WB}, {31'd0, e.rw});
      end
    end
  end

  // Memory-request monitor: compare on rising req, verify fields held until it drops.
  logic req_prev = 1'b0;
  logic hold_bad = 1'b0;
  req_t cur;
  always @(negedge clk) begin
    if (dmem_req === 1'b1 && !req_prev) begin
      cur      = '{addr: dmem_addr, wdata: dmem_wdata, we: dmem_we};
      hold_bad = 1'b0;
      if (req_q.size() == 0) begin
        check("dmem_unexpected", 32'd1, 32'd0);
      end else begin
        req_t e;
        e = req_q.pop_front();
        check("dmem_addr", dmem_addr, e.addr);
        check("dmem_wdata", dmem_wdata, e.wdata);
        check("dmem_we", {31'd0, dmem_we}, {31'd0, e.we});
      end
    end else if (dmem_req === 1'b1) begin
      if (dmem_addr !== cur.addr || dmem_wdata !== cur.wdata || dmem_we !== cur.we)
        hold_bad = 1'b1;
    end else if (req_prev) begin
      check("dmem_hold", {31'd0, hold_bad}, 32'd0);
    end
    req_prev = (dmem_req === 1'b1);
  end

  task automatic set_inputs(input logic br, input logic zr, input logic [31:0] pcb,
                            input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                            input logic mr, input logic mw, input logic mtr, input logic rw);
    branch_MEM    = br;  zero_MEM     = zr;  pc_branch_MEM = pcb;
    alu_MEM       = alu; writedata_MEM = wd; rd_MEM        = rd;
    memread_MEM   = mr;  memwrite_MEM = mw;  memtoreg_MEM  = mtr;
    regwrite_MEM  = rw;
  endtask

  // Called at a negedge; returns at the negedge after the instruction retires.
  task automatic issue(input string name, input logic br, input logic zr, input logic [31:0] pcb,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic mr, input logic mw, input logic mtr, input logic rw,
                       input logic [31:0] rdata, input int lat, input logic exp_pcsrc,
                       input int exp_stall, input int exp_req, input logic [31:0] exp_rd_wb);
    int   stall_n = 0;
    int   req_n   = 0;
    logic bubble_bad = 1'b0;
    set_inputs(br, zr, pcb, alu, wd, rd, mr, mw, mtr, rw);
    resp_data    = rdata;
    ready_lat    = lat;
    issue_active = 1'b1;
    wb_q.push_back('{alu: alu, rdata: exp_rd_wb, rd: rd, mtr: mtr, rw: rw});
    if (mr | mw) req_q.push_back('{addr: alu, wdata: wd, we: mw});
    #1;
    check({name, "_pcsrc"}, {31'd0, pcsrc}, {31'd0, exp_pcsrc});
    check({name, "_pc_target"}, pc_target, pcb);
    for (int i = 0; i < 40; i++) begin
      if (stall !== 1'b1) break;
      if (stall_n > 0 && (regwrite_WB !== 1'b0 || memtoreg_WB !== 1'b0)) bubble_bad = 1'b1;
      if (dmem_req === 1'b1) req_n++;
      stall_n++;
      @(negedge clk);
    end
    check({name, "_stall_cycles"}, stall_n, exp_stall);
    check({name, "_req_cycles"}, req_n, exp_req);
    check({name, "_bubble"}, {31'd0, bubble_bad}, 32'd0);
    $display("[TB] %s: stall=%0d req=%0d", name, stall_n, req_n);
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    issue_active = 1'b0;
    set_inputs(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_dmem_req"}, {31'd0, dmem_req}, 32'd0);
    check({name, "_stall"}, {31'd0, stall}, 32'd0);
    check({name, "_alu_WB"}, alu_WB, 32'd0);
    check({name, "_readdata_WB"}, readdata_WB, 32'd0);
    check({name, "_wb_ctrl"}, {25'd0, rd_WB, memtoreg_WB, regwrite_WB}, 32'd0);
    check({name, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    set_inputs(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    check("reset_dmem_addr", dmem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //     name      br zr pcb     alu      wd        rd mr mw mtr rw rdata     lat pcs st rq rd_wb
    issue("load",    0, 0, 32'h0, 32'h40, 32'h0,    3, 1, 0, 1, 1, 32'h1234, 3, 0, 4, 3, 32'h1234);
    issue("store",   0, 0, 32'h0, 32'h80, 32'hCAFE, 0, 0, 1, 0, 0, 32'h5555, 1, 0, 2, 1, 32'h0);
    issue("add",     0, 0, 32'h0, 32'h5,  32'h0,    7, 0, 0, 0, 1, 32'h0,    0, 0, 0, 0, 32'h0);
    issue("br_take", 1, 1, 32'h100, 32'h0, 32'h0,   0, 0, 0, 0, 0, 32'h0,    0, 1, 0, 0, 32'h0);
    issue("br_not",  1, 0, 32'h100, 32'h1, 32'h0,   0, 0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0);
    issue("load2",   0, 0, 32'h0, 32'hC4, 32'h0,    9, 1, 0, 1, 1, 32'hA5A5, 1, 0, 2, 1, 32'hA5A5);
    issue("rw_both", 0, 0, 32'h0, 32'h88, 32'h77,   4, 1, 1, 0, 0, 32'h9999, 2, 0, 3, 2, 32'h0);
    nop(2);
    check("no_spurious_req", {31'd0, dmem_req}, 32'd0);

`ifdef DMEM_TIMEOUT_EN
    issue("timeout", 0, 0, 32'h0, 32'h60, 32'h0,    5, 1, 0, 1, 1, 32'h1111, 0, 0, 5, 4, 32'hDEADBEEF);
    check("err_set", {31'd0, err}, 32'd1);
    nop(3);
    check("err_sticky", {31'd0, err}, 32'd1);
    issue("load_after_to", 0, 0, 32'h0, 32'h64, 32'h0, 6, 1, 0, 1, 1, 32'h2222, 1, 0, 2, 1, 32'h2222);
    check("err_sticky2", {31'd0, err}, 32'd1);
`else
    check("err_tied", {31'd0, err}, 32'd0);
`endif

    // Reset while a request is outstanding and memory never answers.
    set_inputs(1'b0, 1'b0, '0, 32'h200, '0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    ready_lat    = 0;
    issue_active = 1'b0;
    req_q.push_back('{addr: 32'h200, wdata: 32'h0, we: 1'b0});
    repeat (3) @(negedge clk);
    check("rst_in_req_pre", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    set_inputs(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_reset_state("rst_in_req");
    rst = 1'b0;
    @(negedge clk);

    issue("add_post", 0, 0, 32'h0, 32'h9, 32'h0, 1, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0, 32'h0);
    nop(2);
    check("wb_q_empty", wb_q.size(), 32'd0);
    check("req_q_empty", req_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
